// File: rtl/vga_frame_sequencer.sv
// Raster timing generator: pixel-clock divider, x/y counters, sync/active decode,
// and a once-per-frame vblank update handshake with overrun detection.
module vga_frame_sequencer #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       upd_req,
    input  logic       upd_ack,
    output logic       overrun
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_pix_tick;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;
    logic             r_upd_req;
    logic             r_overrun;

    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             w_wrap;
    logic             w_vblank_entry;

    // Every registered output is decoded from the next coordinates so it lines up with x/y.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (r_pix_tick) begin
            if (r_x == H_LAST) begin
                w_x_next = '0;
                w_y_next = (r_y == V_LAST) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
        w_wrap         = r_pix_tick && (w_x_next == '0) && (w_y_next == '0);
        w_vblank_entry = r_pix_tick && (w_x_next == '0) && (w_y_next == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_div_cnt     <= '0;
            r_pix_tick    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b1;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_upd_req     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_div_cnt     <= (r_div_cnt == CNT_MAX) ? '0 : r_div_cnt + CNT_W'(1);
            r_pix_tick    <= (r_div_cnt == CNT_MAX);
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_active      <= (w_x_next < H_ACT) && (w_y_next < V_ACT);
            r_hsync       <= !((w_x_next >= HS_BEGIN) && (w_x_next < HS_END));
            r_vsync       <= !((w_y_next >= VS_BEGIN) && (w_y_next < VS_END));
            r_frame_start <= w_wrap;
            r_overrun     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vblank_entry) begin
                        r_state   <= ST_REQ;
                        r_upd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // An ack landing on the frame wrap wins and closes the frame cleanly.
                    if (upd_ack) begin
                        r_state   <= w_wrap ? ST_IDLE : ST_DONE;
                        r_upd_req <= 1'b0;
                    end else if (w_wrap) begin
                        r_state   <= ST_IDLE;
                        r_upd_req <= 1'b0;
                        r_overrun <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_wrap) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_upd_req <= 1'b0;
                end
            endcase
        end
    end

    assign pix_tick    = r_pix_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign active      = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign upd_req     = r_upd_req;
    assign overrun     = r_overrun;

endmodule
